poly_operand_driver: RTL and testbench

- Initiator side of the Go/DataIn operand-load handshake used by the polynomial evaluator datapath/control pair.
- Accepts a packed operand word {A,B,C,X} on a Start request. Presents each operand on DataOut and strobes Go with programmable high/low widths, in the order A, B, C, X.
- Then waits for the evaluator's ResultValid pulse, captures the 8-bit result and signals Done.
- Sits between switch/host logic and the evaluator; replaces manual KEY[1] pressing.

---
 rtl/poly_pkg.sv | 34 +++
 rtl/poly_operand_driver_phase_timer.sv | 37 +++
 rtl/poly_operand_driver.sv | 178 +++++++++++++++++
 tb/tb_poly_operand_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared types and helpers for the polynomial evaluator operand driver.
package poly_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESENT  = 3'd1,
        S_RELEASE  = 3'd2,
        S_WAIT_RES = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_A = 2'd0,
        OP_B = 2'd1,
        OP_C = 2'd2,
        OP_X = 2'd3
    } op_idx_e;

    localparam int unsigned NUM_OPS    = 4;
    localparam int unsigned DEF_DATA_W = 8;

    // LSB of operand idx inside the packed {A,B,C,X} word (A sits in the MSBs)
    function automatic int unsigned op_lsb(input int unsigned idx, input int unsigned w);
        return (NUM_OPS - 1 - idx) * w;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/poly_operand_driver_phase_timer.sv
// Loadable down-counter; expire_o is high while the count is at its last cycle (or idle at 0).
module phase_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             expire_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // expire is registered alongside the count so it always reflects cnt_q <= 1
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            expire_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= (cnt_d <= WIDTH'(1));
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/poly_operand_driver.sv
// Drives operands A,B,C,X onto the evaluator Go/DataIn handshake, then waits for and
// captures the result, flagging a sticky Error if it does not arrive in time.
module poly_operand_driver
    import poly_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_W,
    parameter int unsigned GO_HIGH_CYCLES = 2,
    parameter int unsigned GO_LOW_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] operands_i,
    output logic                          busy_o,
    output logic                          go_o,
    output logic [DATA_WIDTH-1:0]         data_out_o,
    input  logic [DATA_WIDTH-1:0]         result_in_i,
    input  logic                          result_valid_i,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic                          done_o,
    output logic                          error_o
);

    localparam int unsigned CNT_MAX = max3(GO_HIGH_CYCLES, GO_LOW_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (GO_HIGH_CYCLES == 0) begin : g_bad_high
        $error("GO_HIGH_CYCLES must be at least 1");
    end
    if (GO_LOW_CYCLES == 0 || GO_LOW_CYCLES > 5) begin : g_bad_low
        $error("GO_LOW_CYCLES must be in 1..5");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                          state_q, state_d;
    op_idx_e                         idx_q, idx_d;
    logic [NUM_OPS*DATA_WIDTH-1:0]   ops_q, ops_d;
    logic                            go_q, go_d;
    logic                            busy_q, busy_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic [DATA_WIDTH-1:0]           result_q, result_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;
    logic                            tmr_load_c;
    logic [CNT_W-1:0]                tmr_val_c;
    logic                            tmr_expire;
    op_idx_e                         idx_next_c;

    logic [DATA_WIDTH-1:0] in_ops  [NUM_OPS];
    logic [DATA_WIDTH-1:0] lat_ops [NUM_OPS];

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_unpack
        assign in_ops[i]  = operands_i[op_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        assign lat_ops[i] = ops_q[op_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end

    assign idx_next_c = op_idx_e'(idx_q + 2'd1);

    phase_timer #(.WIDTH(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .expire_o   (tmr_expire)
    );

    // Next-state and registered-output logic; timer is reloaded on every state entry
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ops_d      = ops_q;
        data_d     = data_q;
        result_d   = result_q;
        error_d    = error_q;
        go_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ops_d      = operands_i;
                    idx_d      = OP_A;
                    error_d    = 1'b0;
                    data_d     = in_ops[OP_A];
                    go_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_PRESENT;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(GO_HIGH_CYCLES);
                end
            end
            S_PRESENT: begin
                busy_d = 1'b1;
                go_d   = 1'b1;
                if (tmr_expire) begin
                    go_d       = 1'b0;
                    state_d    = S_RELEASE;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = CNT_W'(GO_LOW_CYCLES);
                end
            end
            S_RELEASE: begin
                busy_d = 1'b1;
                if (tmr_expire) begin
                    tmr_load_c = 1'b1;
                    if (idx_q == OP_X) begin
                        state_d   = S_WAIT_RES;
                        tmr_val_c = CNT_W'(TIMEOUT_CYCLES);
                    end else begin
                        idx_d     = idx_next_c;
                        data_d    = lat_ops[idx_next_c];
                        go_d      = 1'b1;
                        state_d   = S_PRESENT;
                        tmr_val_c = CNT_W'(GO_HIGH_CYCLES);
                    end
                end
            end
            S_WAIT_RES: begin
                busy_d = 1'b1;
                // A result arriving on the expiry cycle still wins over the timeout
                if (result_valid_i) begin
                    result_d = result_in_i;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else if (tmr_expire) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= OP_A;
            ops_q    <= '0;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ops_q    <= ops_d;
            go_q     <= go_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            result_q <= result_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign busy_o     = busy_q;
    assign go_o       = go_q;
    assign data_out_o = data_q;
    assign result_o   = result_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_poly_operand_driver.sv
// Bench for poly_operand_driver with an evaluator stub and a cycle-level timing model.
module tb_poly_operand_driver;

    localparam int unsigned DW = 8;
    localparam int unsigned H  = 2;
    localparam int unsigned L  = 2;
    localparam int unsigned T  = 16;
    localparam int          P  = H + L;
    localparam int          WAIT_START = 4 * P + 1;
    localparam int          LAST_FALL  = 4 * P - L + 1;

    logic          clk = 1'b0;
    logic          reset, start, valid;
    logic [31:0]   operands;
    logic [DW-1:0] result_in;
    logic          busy, go, done, error;
    logic [DW-1:0] data_out, result;

    int checks = 0;
    int errors = 0;

    logic          tr_go   [0:63];
    logic          tr_busy [0:63];
    logic          tr_done [0:63];
    logic          tr_err  [0:63];
    logic [DW-1:0] tr_data [0:63];
    logic [DW-1:0] tr_res  [0:63];

    poly_operand_driver #(
        .DATA_WIDTH     (DW),
        .GO_HIGH_CYCLES (H),
        .GO_LOW_CYCLES  (L),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .operands_i     (operands),
        .busy_o         (busy),
        .go_o           (go),
        .data_out_o     (data_out),
        .result_in_i    (result_in),
        .result_valid_i (valid),
        .result_o       (result),
        .done_o         (done),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    // Reference model: polynomial A*X^2 + B*X + C, truncated to 8 bits
    function automatic logic [DW-1:0] poly_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c, input logic [DW-1:0] x);
        int unsigned r;
        r = 32'(a) * 32'(x) * 32'(x) + 32'(b) * 32'(x) + 32'(c);
        return DW'(r);
    endfunction

    function automatic logic [DW-1:0] op_of(input logic [31:0] ops, input int n);
        return DW'(ops >> (8 * (3 - n)));
    endfunction

    function automatic logic [DW-1:0] exp_result(input logic [31:0] ops);
        return poly_ref(op_of(ops, 0), op_of(ops, 1), op_of(ops, 2), op_of(ops, 3));
    endfunction

    function automatic logic exp_go(input int k);
        return (k >= 1) && (k <= 4 * P) && (((k - 1) % P) < H);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [31:0] ops, input int k);
        int n;
        n = (k - 1) / P;
        if (n > 3) n = 3;
        return op_of(ops, n);
    endfunction

    // v = cycle the result pulse lands in WAIT_RES, or -1 for a timeout
    function automatic logic exp_busy(input int k, input int v);
        int last;
        last = (v >= 0) ? v : 4 * P + T;
        return (k >= 1) && (k <= last);
    endfunction

    function automatic logic exp_done(input int k, input int v);
        return (v >= 0) && (k == v + 1);
    endfunction

    // Start is driven in cycle 0; cycles 1..ncyc are traced. The evaluator stub captures
    // operands on Go rising and answers resp_delay cycles after the last Go falls.
    task automatic run_txn(input logic [31:0] ops, input int resp_delay,
                           input logic [63:0] start_mask, input logic [63:0] valid_mask,
                           input int reset_cyc, input int ncyc);
        logic [DW-1:0] cap [4];
        int   ncap;
        int   fire;
        logic prev_go;
        ncap    = 0;
        fire    = -1;
        prev_go = 1'b0;
        foreach (cap[i]) cap[i] = '0;
        @(posedge clk); #1;
        start    = 1'b1;
        operands = ops;
        valid    = 1'b0;
        reset    = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start    = start_mask[k];
            operands = start_mask[k] ? ~ops : ops;
            reset    = (k == reset_cyc);
            if (k == fire) begin
                valid     = 1'b1;
                result_in = poly_ref(cap[0], cap[1], cap[2], cap[3]);
            end else if (valid_mask[k]) begin
                valid     = 1'b1;
                result_in = 8'hEE;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
            tr_go[k]   = go;
            tr_busy[k] = busy;
            tr_done[k] = done;
            tr_err[k]  = error;
            tr_data[k] = data_out;
            tr_res[k]  = result;
            if (go && !prev_go && ncap < 4) begin
                cap[ncap] = data_out;
                ncap++;
            end
            if (!go && prev_go && ncap == 4 && resp_delay >= 0 && fire < 0)
                fire = k + resp_delay;
            prev_go = go;
        end
        start = 1'b0;
        valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; valid = 1'b0; operands = '0; result_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", go); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] ops = 32'h01020302;
        int v = LAST_FALL + 5;
        run_txn(ops, 5, '0, '0, -1, 23);
        for (int k = 1; k <= 23; k++) begin
            checks++; if (tr_go[k] !== exp_go(k)) begin errors++; $display("FAIL basic_go cyc %0d got %b want %b", k, tr_go[k], exp_go(k)); end
            checks++; if (tr_busy[k] !== exp_busy(k, v)) begin errors++; $display("FAIL basic_busy cyc %0d got %b want %b", k, tr_busy[k], exp_busy(k, v)); end
            checks++; if (tr_done[k] !== exp_done(k, v)) begin errors++; $display("FAIL basic_done cyc %0d got %b want %b", k, tr_done[k], exp_done(k, v)); end
            checks++; if (tr_data[k] !== exp_data(ops, k)) begin errors++; $display("FAIL basic_data cyc %0d got %h want %h", k, tr_data[k], exp_data(ops, k)); end
        end
        checks++; if (tr_res[23] !== 8'h0B) begin errors++; $display("FAIL basic_result got %h want 0b", tr_res[23]); end
        checks++; if (tr_err[23] !== 1'b0) begin errors++; $display("FAIL basic_error got %b want 0", tr_err[23]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops = 32'h03050704;
        run_txn(ops, 5, '0, '0, -1, 21);
        checks++; if (tr_done[21] !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", tr_done[21]); end
        checks++; if (tr_res[21] !== 8'h4B) begin errors++; $display("FAIL b2b_result1 got %h want 4b", tr_res[21]); end
        run_txn(ops, 5, '0, '0, -1, 23);
        for (int k = 1; k <= 16; k++) begin
            checks++; if (tr_go[k] !== exp_go(k)) begin errors++; $display("FAIL b2b_go cyc %0d got %b want %b", k, tr_go[k], exp_go(k)); end
        end
        checks++; if (tr_done[21] !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", tr_done[21]); end
        checks++; if (tr_res[21] !== 8'h4B) begin errors++; $display("FAIL b2b_result2 got %h want 4b", tr_res[21]); end
        checks++; if (tr_busy[22] !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", tr_busy[22]); end
    endtask

    task automatic test_wrap();
        logic [31:0] ops = 32'h10000510;
        run_txn(ops, 5, '0, '0, -1, 22);
        checks++; if (tr_done[21] !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", tr_done[21]); end
        checks++; if (tr_res[22] !== 8'h05) begin errors++; $display("FAIL wrap_result got %h want 05", tr_res[22]); end
    endtask

    task automatic test_timeout();
        logic [31:0] ops = 32'h0A0B0C0D;
        logic [31:0] ops2 = 32'h02030405;
        logic [DW-1:0] prev_res;
        prev_res = result;
        run_txn(ops, -1, '0, '0, -1, 36);
        for (int k = 1; k <= 36; k++) begin
            checks++; if (tr_busy[k] !== exp_busy(k, -1)) begin errors++; $display("FAIL timeout_busy cyc %0d got %b want %b", k, tr_busy[k], exp_busy(k, -1)); end
            checks++; if (tr_done[k] !== 1'b0) begin errors++; $display("FAIL timeout_done cyc %0d got %b want 0", k, tr_done[k]); end
            checks++; if (tr_err[k] !== (k >= WAIT_START + T)) begin errors++; $display("FAIL timeout_error cyc %0d got %b want %b", k, tr_err[k], k >= WAIT_START + T); end
        end
        checks++; if (tr_res[36] !== prev_res) begin errors++; $display("FAIL timeout_result_held got %h want %h", tr_res[36], prev_res); end
        run_txn(ops2, 5, '0, '0, -1, 22);
        checks++; if (tr_err[1] !== 1'b0) begin errors++; $display("FAIL error_clear got %b want 0", tr_err[1]); end
        checks++; if (tr_res[22] !== 8'h45) begin errors++; $display("FAIL error_clear_result got %h want 45", tr_res[22]); end
    endtask

    task automatic test_valid_at_timeout();
        logic [31:0] ops = 32'h07060504;
        int v = LAST_FALL + 17;
        run_txn(ops, 17, '0, '0, -1, v + 2);
        checks++; if (tr_done[v + 1] !== 1'b1) begin errors++; $display("FAIL edge_done got %b want 1", tr_done[v + 1]); end
        checks++; if (tr_err[v + 1] !== 1'b0) begin errors++; $display("FAIL edge_error got %b want 0", tr_err[v + 1]); end
        checks++; if (tr_res[v + 1] !== exp_result(ops)) begin errors++; $display("FAIL edge_result got %h want %h", tr_res[v + 1], exp_result(ops)); end
    endtask

    task automatic test_ignored();
        logic [31:0] ops = 32'h09080706;
        logic [63:0] smask = '0;
        logic [63:0] vmask = '0;
        int v = LAST_FALL + 5;
        smask[5]  = 1'b1;
        smask[21] = 1'b1;
        vmask[11] = 1'b1;
        vmask[16] = 1'b1;
        run_txn(ops, 5, smask, vmask, -1, 23);
        for (int k = 1; k <= 23; k++) begin
            checks++; if (tr_go[k] !== exp_go(k)) begin errors++; $display("FAIL ign_go cyc %0d got %b want %b", k, tr_go[k], exp_go(k)); end
            checks++; if (tr_busy[k] !== exp_busy(k, v)) begin errors++; $display("FAIL ign_busy cyc %0d got %b want %b", k, tr_busy[k], exp_busy(k, v)); end
            checks++; if (tr_done[k] !== exp_done(k, v)) begin errors++; $display("FAIL ign_done cyc %0d got %b want %b", k, tr_done[k], exp_done(k, v)); end
            checks++; if (tr_data[k] !== exp_data(ops, k)) begin errors++; $display("FAIL ign_data cyc %0d got %h want %h", k, tr_data[k], exp_data(ops, k)); end
        end
        checks++; if (tr_res[23] !== exp_result(ops)) begin errors++; $display("FAIL ign_result got %h want %h", tr_res[23], exp_result(ops)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ops = 32'h05040302;
        logic [31:0] ops2 = 32'h01020302;
        run_txn(ops, 5, '0, '0, 9, 12);
        checks++; if (tr_go[9] !== 1'b1) begin errors++; $display("FAIL rmid_go_before got %b want 1", tr_go[9]); end
        for (int k = 10; k <= 12; k++) begin
            checks++; if (tr_go[k] !== 1'b0) begin errors++; $display("FAIL rmid_go cyc %0d got %b want 0", k, tr_go[k]); end
            checks++; if (tr_busy[k] !== 1'b0) begin errors++; $display("FAIL rmid_busy cyc %0d got %b want 0", k, tr_busy[k]); end
            checks++; if (tr_res[k] !== 8'h00) begin errors++; $display("FAIL rmid_result cyc %0d got %h want 00", k, tr_res[k]); end
            checks++; if (tr_data[k] !== 8'h00) begin errors++; $display("FAIL rmid_data cyc %0d got %h want 00", k, tr_data[k]); end
        end
        run_txn(ops2, 5, '0, '0, -1, 22);
        checks++; if (tr_done[21] !== 1'b1) begin errors++; $display("FAIL rmid_fresh_done got %b want 1", tr_done[21]); end
        checks++; if (tr_res[22] !== 8'h0B) begin errors++; $display("FAIL rmid_fresh_result got %h want 0b", tr_res[22]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] ops;
            int d, v;
            ops = $urandom;
            d   = int'($urandom_range(2, 17));
            v   = LAST_FALL + d;
            run_txn(ops, d, '0, '0, -1, v + 2);
            for (int k = 1; k <= 4 * P; k++) begin
                checks++; if (tr_data[k] !== exp_data(ops, k)) begin errors++; $display("FAIL rand_data it %0d cyc %0d got %h want %h", it, k, tr_data[k], exp_data(ops, k)); end
            end
            checks++; if (tr_done[v + 1] !== 1'b1) begin errors++; $display("FAIL rand_done it %0d got %b want 1", it, tr_done[v + 1]); end
            checks++; if (tr_busy[v] !== 1'b1 || tr_busy[v + 1] !== 1'b0) begin errors++; $display("FAIL rand_busy it %0d got %b%b want 10", it, tr_busy[v], tr_busy[v + 1]); end
            checks++; if (tr_res[v + 2] !== exp_result(ops)) begin errors++; $display("FAIL rand_result it %0d got %h want %h", it, tr_res[v + 2], exp_result(ops)); end
            checks++; if (tr_err[v + 2] !== 1'b0) begin errors++; $display("FAIL rand_error it %0d got %b want 0", it, tr_err[v + 2]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_valid_at_timeout();
        test_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
